// File: rtl/tx_stop_ser_pkg.sv
// Shared link constants for the comma-aligned serial link.
// Used by both the transmitter and the receiver so comma patterns match.
package tx_stop_ser_pkg;

    localparam int SYM_W   = 10;
    localparam int BIT_DIV = 4;

    localparam logic [SYM_W-1:0] COMMA_A = 10'b1010000011;
    localparam logic [SYM_W-1:0] COMMA_B = 10'b0101111100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA
    } tx_state_e;

    // Fill symbols alternate B, A, B, ... starting from gap count 0.
    function automatic logic [SYM_W-1:0] fill_sym(input logic [3:0] gap);
        return gap[0] ? COMMA_A : COMMA_B;
    endfunction

endpackage

// File: rtl/tx_stop_ser_bit_timer.sv
// Bit/word timer: counts DIV clocks per bit and 10 bits per word.
// Ports: clk, rst_n, run (counters held at 0 when low), bit_end, word_end.
module tx_bit_timer
    import tx_stop_ser_pkg::*;
#(
    parameter int DIV = BIT_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_end,
    output logic word_end
);

    localparam int DW = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_end   = run && (div_cnt_q == DW'(DIV - 1));
        word_end  = bit_end && (bit_cnt_q == 4'd9);
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (!run) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
            if (word_end) begin
                bit_cnt_d = '0;
            end else if (bit_end) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/tx_stop_ser.sv
// 10-bit LSB-first serializer with comma preamble and comma gap fill.
// Ports: clk, rst_n, din/din_valid/din_ready handshake, sync_req, LVDS, busy.
module tx_stop_ser
    import tx_stop_ser_pkg::*;
#(
    parameter int DIV     = BIT_DIV,
    parameter int GAP_MAX = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sync_req,
    output logic             LVDS,
    output logic             busy
);

    tx_state_e        state_q, state_d;
    logic [SYM_W-1:0] shift_q, shift_d;
    logic [1:0]       sync_idx_q, sync_idx_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             sync_pending_q, sync_pending_d;

    logic run;
    logic bit_end;
    logic word_end;
    logic pend;
    logic go_data;

    assign run = (state_q != ST_IDLE);

    tx_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .bit_end (bit_end),
        .word_end(word_end)
    );

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        sync_idx_d     = sync_idx_q;
        gap_cnt_d      = gap_cnt_q;
        din_ready      = 1'b0;
        go_data        = 1'b0;
        // A request landing on a word boundary is honoured at that boundary.
        pend           = sync_pending_q | sync_req;
        sync_pending_d = pend;

        if (bit_end) begin
            shift_d = {1'b0, shift_q[SYM_W-1:1]};
        end

        unique case (state_q)
            ST_IDLE: begin
                // Every burst opens with a preamble anyway.
                sync_pending_d = 1'b0;
                shift_d        = '0;
                if (din_valid) begin
                    state_d    = ST_SYNC;
                    shift_d    = COMMA_A;
                    sync_idx_d = 2'd0;
                    gap_cnt_d  = 4'd0;
                end
            end
            ST_SYNC: begin
                if (word_end) begin
                    if (sync_idx_q != 2'd2) begin
                        sync_idx_d = sync_idx_q + 2'd1;
                        shift_d    = (sync_idx_q == 2'd0) ? COMMA_B : COMMA_A;
                    end else begin
                        go_data = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                go_data = word_end;
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
            end
        endcase

        if (go_data) begin
            state_d = ST_DATA;
            if (pend) begin
                state_d        = ST_SYNC;
                shift_d        = COMMA_A;
                sync_idx_d     = 2'd0;
                sync_pending_d = 1'b0;
                gap_cnt_d      = 4'd0;
            end else if (din_valid) begin
                din_ready = 1'b1;
                shift_d   = din;
                gap_cnt_d = 4'd0;
            end else if (gap_cnt_q < 4'(GAP_MAX)) begin
                shift_d   = fill_sym(gap_cnt_q);
                gap_cnt_d = gap_cnt_q + 4'd1;
            end else begin
                state_d   = ST_IDLE;
                shift_d   = '0;
                gap_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            sync_idx_q     <= '0;
            gap_cnt_q      <= '0;
            sync_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            sync_idx_q     <= sync_idx_d;
            gap_cnt_q      <= gap_cnt_d;
            sync_pending_q <= sync_pending_d;
        end
    end

    assign LVDS = shift_q[0];
    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/tx_stop_ser.md
Name: tx_stop_ser

Overview:
- 10-bit symbol serializer driving the 20 Mbit/s LVDS line; 80 MHz system clock, one bit every DIV clocks, LSB first.
- Transmit end of the link decoded by the comma-aligning receiver.
- Each burst opens with a 3-symbol comma preamble (A,B,A) so the far end locks its word boundary.
- Gaps are filled with commas; after GAP_MAX consecutive fill symbols the line goes quiet.

Parameters:
- DIV, 4, clk cycles per bit (80 MHz / 20 Mbit/s).
- COMMA_A, 10'b1010000011, preamble symbols 1 and 3, odd fill symbols.
- COMMA_B, 10'b0101111100, preamble symbol 2, even fill symbols.
- GAP_MAX, 2, consecutive fill symbols before returning to IDLE; range 1..15.

Ports:
- clk  in  1  80 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  10  symbol to send; bit 0 transmitted first.
- din_valid  in  1  din holds a symbol.
- din_ready  out  1  combinational; a symbol transfers when din_valid && din_ready.
- sync_req  in  1  single-cycle pulse: force a new preamble at the next word boundary.
- LVDS  out  1  registered serial output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any time, mid-word included): state=IDLE, div_cnt=0, bit_cnt=0, shift=0, gap_cnt=0, LVDS=0, busy=0, sync_pending=0. Output values are final the moment rst_n falls. The partial word is dropped without completion.
- Bit timing: div_cnt counts 0..DIV-1 and wraps. bit_end = (div_cnt==DIV-1). On bit_end, bit_cnt increments 0..9 and wraps. LVDS = shift[0], held for exactly DIV clocks. shift moves right on each bit_end.
- word_end = bit_end && bit_cnt==9. On word_end the next symbol loads into shift, and its bit 0 appears on LVDS the following cycle. Word period is 10*DIV = 40 clk with no dead cycles between words.
- States:
  - IDLE: LVDS=0, counters held at 0, din_ready=0. On din_valid, go to SYNC next cycle with shift=COMMA_A, sync_idx=0. din is not consumed.
  - SYNC: sends COMMA_A, COMMA_B, COMMA_A. At word_end: if sync_idx<2, load the next comma and increment sync_idx. If sync_idx==2, go to DATA and apply the DATA load rule in that same cycle.
  - DATA load rule at word_end, in priority order:
    - sync_pending: load COMMA_A, go to SYNC with sync_idx=0, clear sync_pending, din_ready=0.
    - else din_valid: din_ready=1, load din, gap_cnt=0.
    - else gap_cnt<GAP_MAX: load fill symbol (COMMA_B when gap_cnt even, COMMA_A when odd), increment gap_cnt.
    - else gap_cnt==GAP_MAX: go to IDLE, LVDS=0 next cycle.
- din_ready is 1 only on a DATA-load word_end cycle, including the SYNC→DATA transition cycle. It is never asserted in IDLE or mid-word. A symbol is accepted only on that cycle.
- sync_req: sets sync_pending in any state. In IDLE it is ignored (cleared), because every burst already starts with a preamble. If sync_req and word_end coincide, the current boundary honours it.
- Latency: din_valid rising in IDLE → first preamble bit on LVDS 1 clk later → first data bit 3*40+1 = 121 clk after the din_valid edge.
- No symbol is lost or duplicated. A din_valid deasserted before word_end is simply not taken.
- busy = (state != IDLE).

Decomposition:
- Shared link package holds COMMA_A, COMMA_B, SYM_W=10, and BIT_DIV=4, so receiver and transmitter use identical constants.
- One natural sub-module: tx_bit_timer (div_cnt/bit_cnt, outputs bit_end and word_end).
- FSM, shift register, and handshake live in the top.

Test Plan:
- Reset: assert rst_n=0 mid-word → LVDS=0, busy=0, din_ready=0 immediately. Release, keep din_valid=0 for 200 clk → LVDS stays 0.
- Single word: din=10'h2A5, valid held until accepted.
  - LVDS bit sequence is COMMA_A, COMMA_B, COMMA_A, then 0x2A5 (LSB first), then COMMA_B, COMMA_A, then IDLE.
  - Each bit lasts 4 clk; din_ready pulses once, at clk 120 after din_valid.
  - Loopback into the receiver yields dout=0x2A5 with valid.
- Back-to-back stream: 8 words 0x001..0x008 with din_valid held → no fill symbols between them, 8 din_ready pulses exactly 40 clk apart, receiver outputs all 8 in order.
- Gap: send 0x155, drop valid for 50 clk, send 0x0AA → output is 0x155, COMMA_B, 0x0AA with gap_cnt reset; no preamble is re-sent and busy stays 1.
- sync_req mid-stream: pulse during word 3 of a continuous stream → the next three symbols are A, B, A and the data stream resumes after them with no word dropped.
- GAP_MAX=1 build: a single word is followed by exactly one COMMA_B, then LVDS=0 and busy=0 at the next word boundary.
